alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// ============================================================================
// alu_issue : single-issue RV32I OP/OP-IMM decoder and sequencer for an external ALU
// Revision  : 1.0
// ============================================================================
`default_nettype none

module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1Val,
  input  logic [31:0] rs2Val,
  output logic [31:0] srcA,
  output logic [31:0] srcB,
  output logic [3:0]  aluCTRL,
  input  logic [31:0] aluRes,
  input  logic        aluZero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [4:0]  rd,
  output logic        zero,
  output logic        illegal
);

  localparam logic [3:0] CTRL_ADD  = 4'b0000;
  localparam logic [3:0] CTRL_SLT  = 4'b0001;
  localparam logic [3:0] CTRL_SLTU = 4'b0010;
  localparam logic [3:0] CTRL_XOR  = 4'b0011;
  localparam logic [3:0] CTRL_OR   = 4'b0100;
  localparam logic [3:0] CTRL_AND  = 4'b0101;
  localparam logic [3:0] CTRL_SLL  = 4'b0110;
  localparam logic [3:0] CTRL_SR   = 4'b0111;
  localparam logic [3:0] CTRL_SUB  = 4'b1000;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        dec_legal;
  logic [3:0]  dec_ctrl;
  logic [31:0] dec_srcb;
  logic        accept;
  logic        unused_rs1_field;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // Register specifiers for rs1/rs2 arrive pre-read as rs1Val/rs2Val.
  assign unused_rs1_field = ^instr[19:15];

  function automatic logic [3:0] base_ctrl(input logic [2:0] f3);
    case (f3)
      3'b000:  base_ctrl = CTRL_ADD;
      3'b001:  base_ctrl = CTRL_SLL;
      3'b010:  base_ctrl = CTRL_SLT;
      3'b011:  base_ctrl = CTRL_SLTU;
      3'b100:  base_ctrl = CTRL_XOR;
      3'b101:  base_ctrl = CTRL_SR;
      3'b110:  base_ctrl = CTRL_OR;
      default: base_ctrl = CTRL_AND;
    endcase
  endfunction

  always_comb begin
    dec_legal = 1'b0;
    dec_ctrl  = CTRL_ADD;
    dec_srcb  = 32'd0;
    case (opcode)
      OPC_OP_IMM: begin
        // srai keeps instr[30] in immediate bit 10, which is what selects arithmetic shift.
        dec_srcb = {{20{instr[31]}}, instr[31:20]};
        dec_ctrl = base_ctrl(funct3);
        case (funct3)
          3'b001:  dec_legal = (funct7 == F7_BASE);
          3'b101:  dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          default: dec_legal = 1'b1;
        endcase
      end
      OPC_OP: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_srcb = {21'b0, instr[30], 5'b0, rs2Val[4:0]};
        end else begin
          dec_srcb = rs2Val;
        end
        if (funct7 == F7_BASE) begin
          dec_legal = 1'b1;
          dec_ctrl  = base_ctrl(funct3);
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000) begin
            dec_legal = 1'b1;
            dec_ctrl  = CTRL_SUB;
          end else if (funct3 == 3'b101) begin
            dec_legal = 1'b1;
            dec_ctrl  = CTRL_SR;
          end
        end
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == RESP);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = dec_legal ? EXEC : RESP;
      EXEC:    state_nxt = RESP;
      RESP:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srcA    <= 32'd0;
      srcB    <= 32'd0;
      aluCTRL <= 4'd0;
      result  <= 32'd0;
      rd      <= 5'd0;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        rd <= instr[11:7];
        if (dec_legal) begin
          srcA    <= rs1Val;
          srcB    <= dec_srcb;
          aluCTRL <= dec_ctrl;
          illegal <= 1'b0;
        end else begin
          // Operand registers stay as they were so the ALU sees no spurious change.
          result  <= 32'd0;
          zero    <= 1'b0;
          illegal <= 1'b1;
        end
      end
      if (state == EXEC) begin
        result <= aluRes;
        zero   <= aluZero;
      end
    end
  end

endmodule

`default_nettype wire
